// File: rtl/int_issue_queue.sv
// rtl/int_issue_queue.sv - in-order integer issue queue with CDB wakeup and dispatch bypass
module int_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int CTRL_W = 17
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_dispatch_en,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [TAG_W-1:0]  i_rd_tag,
  input  logic              i_rs1_rdy,
  input  logic              i_rs2_rdy,
  input  logic [TAG_W-1:0]  i_rs1_tag,
  input  logic [TAG_W-1:0]  i_rs2_tag,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic              i_cdb_valid,
  input  logic [TAG_W-1:0]  i_cdb_tag,
  input  logic [DATA_W-1:0] i_cdb_data,
  input  logic              i_flush,
  input  logic              i_issue_ready,
  output logic              o_issue_valid,
  output logic [CTRL_W-1:0] o_issue_ctrl,
  output logic [TAG_W-1:0]  o_issue_rd_tag,
  output logic [DATA_W-1:0] o_issue_rs1,
  output logic [DATA_W-1:0] o_issue_rs2,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Per-entry control state (reset) and payload (unreset)
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  rs1_rdy_q, rs1_rdy_d;
  logic [DEPTH-1:0]  rs2_rdy_q, rs2_rdy_d;
  logic [TAG_W-1:0]  rs1_tag_q  [DEPTH];
  logic [TAG_W-1:0]  rs1_tag_d  [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_q  [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_d  [DEPTH];
  logic [DATA_W-1:0] rs1_data_q [DEPTH];
  logic [DATA_W-1:0] rs1_data_d [DEPTH];
  logic [DATA_W-1:0] rs2_data_q [DEPTH];
  logic [DATA_W-1:0] rs2_data_d [DEPTH];
  logic [CTRL_W-1:0] ctrl_q     [DEPTH];
  logic [CTRL_W-1:0] ctrl_d     [DEPTH];
  logic [TAG_W-1:0]  rd_tag_q   [DEPTH];
  logic [TAG_W-1:0]  rd_tag_d   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Registered outputs so nothing combinational reaches the ports
  logic              issue_valid_q, issue_valid_d;
  logic [CTRL_W-1:0] issue_ctrl_q, issue_ctrl_d;
  logic [TAG_W-1:0]  issue_rd_tag_q, issue_rd_tag_d;
  logic [DATA_W-1:0] issue_rs1_q, issue_rs1_d;
  logic [DATA_W-1:0] issue_rs2_q, issue_rs2_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  logic push, pop;

  // Next-state: wakeup, pop, push (with bypass), flush, then decode the new head into outputs
  always_comb begin
    valid_d    = valid_q;
    rs1_rdy_d  = rs1_rdy_q;
    rs2_rdy_d  = rs2_rdy_q;
    rs1_tag_d  = rs1_tag_q;
    rs2_tag_d  = rs2_tag_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    ctrl_d     = ctrl_q;
    rd_tag_d   = rd_tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    // Full is judged on registered state: a same-cycle pop never makes room
    push = i_dispatch_en && !full_q;
    pop  = issue_valid_q && i_issue_ready;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !rs1_rdy_q[i] && i_cdb_valid && (i_cdb_tag == rs1_tag_q[i])) begin
        rs1_rdy_d[i]  = 1'b1;
        rs1_data_d[i] = i_cdb_data;
      end
      if (valid_q[i] && !rs2_rdy_q[i] && i_cdb_valid && (i_cdb_tag == rs2_tag_q[i])) begin
        rs2_rdy_d[i]  = 1'b1;
        rs2_data_d[i] = i_cdb_data;
      end
    end

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      valid_d[wr_ptr_q]    = 1'b1;
      ctrl_d[wr_ptr_q]     = i_ctrl;
      rd_tag_d[wr_ptr_q]   = i_rd_tag;
      rs1_tag_d[wr_ptr_q]  = i_rs1_tag;
      rs2_tag_d[wr_ptr_q]  = i_rs2_tag;
      rs1_rdy_d[wr_ptr_q]  = i_rs1_rdy || (i_cdb_valid && (i_cdb_tag == i_rs1_tag));
      rs2_rdy_d[wr_ptr_q]  = i_rs2_rdy || (i_cdb_valid && (i_cdb_tag == i_rs2_tag));
      rs1_data_d[wr_ptr_q] = i_rs1_rdy ? i_rs1_data : i_cdb_data;
      rs2_data_d[wr_ptr_q] = i_rs2_rdy ? i_rs2_data : i_cdb_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (i_flush) begin
      valid_d   = '0;
      rs1_rdy_d = '0;
      rs2_rdy_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end

    full_d         = (count_d == CNT_W'(DEPTH));
    empty_d        = (count_d == '0);
    issue_valid_d  = valid_d[rd_ptr_d] && rs1_rdy_d[rd_ptr_d] && rs2_rdy_d[rd_ptr_d];
    // Payload outputs only move when a new op is presented; otherwise they hold
    issue_ctrl_d   = issue_ctrl_q;
    issue_rd_tag_d = issue_rd_tag_q;
    issue_rs1_d    = issue_rs1_q;
    issue_rs2_d    = issue_rs2_q;
    if (issue_valid_d) begin
      issue_ctrl_d   = ctrl_d[rd_ptr_d];
      issue_rd_tag_d = rd_tag_d[rd_ptr_d];
      issue_rs1_d    = rs1_data_d[rd_ptr_d];
      issue_rs2_d    = rs2_data_d[rd_ptr_d];
    end
  end

  // Control state and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q        <= '0;
      rs1_rdy_q      <= '0;
      rs2_rdy_q      <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      issue_valid_q  <= 1'b0;
      issue_ctrl_q   <= '0;
      issue_rd_tag_q <= '0;
      issue_rs1_q    <= '0;
      issue_rs2_q    <= '0;
    end else begin
      valid_q        <= valid_d;
      rs1_rdy_q      <= rs1_rdy_d;
      rs2_rdy_q      <= rs2_rdy_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      issue_valid_q  <= issue_valid_d;
      issue_ctrl_q   <= issue_ctrl_d;
      issue_rd_tag_q <= issue_rd_tag_d;
      issue_rs1_q    <= issue_rs1_d;
      issue_rs2_q    <= issue_rs2_d;
    end
  end

  // Entry payload storage; meaningless while the matching valid/rdy bit is clear
  always_ff @(posedge i_clk) begin
    rs1_tag_q  <= rs1_tag_d;
    rs2_tag_q  <= rs2_tag_d;
    rs1_data_q <= rs1_data_d;
    rs2_data_q <= rs2_data_d;
    ctrl_q     <= ctrl_d;
    rd_tag_q   <= rd_tag_d;
  end

  assign o_issue_valid  = issue_valid_q;
  assign o_issue_ctrl   = issue_ctrl_q;
  assign o_issue_rd_tag = issue_rd_tag_q;
  assign o_issue_rs1    = issue_rs1_q;
  assign o_issue_rs2    = issue_rs2_q;
  assign o_full         = full_q;
  assign o_empty        = empty_q;

endmodule

// File: tb/tb_int_issue_queue.sv
// tb/tb_int_issue_queue.sv - directed self-checking bench for int_issue_queue
module tb_int_issue_queue;

  logic        clk;
  logic        rst_n;
  logic        dispatch_en;
  logic [16:0] ctrl;
  logic [5:0]  rd_tag;
  logic        rs1_rdy, rs2_rdy;
  logic [5:0]  rs1_tag, rs2_tag;
  logic [31:0] rs1_data, rs2_data;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        flush;
  logic        issue_ready;
  logic        issue_valid;
  logic [16:0] issue_ctrl;
  logic [5:0]  issue_rd_tag;
  logic [31:0] issue_rs1, issue_rs2;
  logic        full, empty;

  int checks   = 0;
  int failures = 0;

  int_issue_queue dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_dispatch_en  (dispatch_en),
    .i_ctrl         (ctrl),
    .i_rd_tag       (rd_tag),
    .i_rs1_rdy      (rs1_rdy),
    .i_rs2_rdy      (rs2_rdy),
    .i_rs1_tag      (rs1_tag),
    .i_rs2_tag      (rs2_tag),
    .i_rs1_data     (rs1_data),
    .i_rs2_data     (rs2_data),
    .i_cdb_valid    (cdb_valid),
    .i_cdb_tag      (cdb_tag),
    .i_cdb_data     (cdb_data),
    .i_flush        (flush),
    .i_issue_ready  (issue_ready),
    .o_issue_valid  (issue_valid),
    .o_issue_ctrl   (issue_ctrl),
    .o_issue_rd_tag (issue_rd_tag),
    .o_issue_rs1    (issue_rs1),
    .o_issue_rs2    (issue_rs2),
    .o_full         (full),
    .o_empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [5:0] rd, input logic r1, input logic [5:0] t1,
                          input logic [31:0] d1, input logic r2, input logic [5:0] t2,
                          input logic [31:0] d2);
    dispatch_en = 1'b1;
    ctrl        = {11'd0, rd};
    rd_tag      = rd;
    rs1_rdy     = r1;
    rs1_tag     = t1;
    rs1_data    = d1;
    rs2_rdy     = r2;
    rs2_tag     = t2;
    rs2_data    = d2;
    step();
    dispatch_en = 1'b0;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
    step();
    cdb_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; dispatch_en = 1'b0; ctrl = '0; rd_tag = '0;
    rs1_rdy = 1'b0; rs2_rdy = 1'b0; rs1_tag = '0; rs2_tag = '0;
    rs1_data = '0; rs2_data = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    flush = 1'b0; issue_ready = 1'b0;

    // 1: reset
    step(); step();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_valid", 64'(issue_valid), 64'd0);
    check("rst_ctrl", 64'(issue_ctrl), 64'd0);
    check("rst_rd_tag", 64'(issue_rd_tag), 64'd0);
    check("rst_rs1", 64'(issue_rs1), 64'd0);
    check("rst_rs2", 64'(issue_rs2), 64'd0);
    rst_n = 1'b1;
    step();

    // 2: fill, overflow dropped, drain in order
    dispatch(6'd1, 1'b1, 6'd0, 32'h10, 1'b1, 6'd0, 32'h1);
    check("fill_first_valid", 64'(issue_valid), 64'd1);
    check("fill_first_tag", 64'(issue_rd_tag), 64'd1);
    for (int k = 2; k <= 4; k++)
      dispatch(6'(k), 1'b1, 6'd0, 32'(16 * k), 1'b1, 6'd0, 32'(k));
    check("fill_full", 64'(full), 64'd1);
    dispatch(6'd5, 1'b1, 6'd0, 32'h50, 1'b1, 6'd0, 32'h5);
    check("over_full", 64'(full), 64'd1);
    check("over_head", 64'(issue_rd_tag), 64'd1);
    issue_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain_valid%0d", k), 64'(issue_valid), 64'd1);
      check($sformatf("drain_tag%0d", k), 64'(issue_rd_tag), 64'(k));
      check($sformatf("drain_ctrl%0d", k), 64'(issue_ctrl), 64'(k));
      check($sformatf("drain_rs1_%0d", k), 64'(issue_rs1), 64'(16 * k));
      step();
    end
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_valid_off", 64'(issue_valid), 64'd0);

    // 3: stalled head blocks younger ready entry until CDB wakes it
    issue_ready = 1'b0;
    dispatch(6'd10, 1'b1, 6'd0, 32'h1, 1'b0, 6'd9, 32'h0);
    dispatch(6'd11, 1'b1, 6'd0, 32'hB1, 1'b1, 6'd0, 32'hB2);
    issue_ready = 1'b1;
    step();
    check("stall_no_bypass", 64'(issue_valid), 64'd0);
    cdb(6'd9, 32'hDEAD);
    check("wake_valid", 64'(issue_valid), 64'd1);
    check("wake_tag", 64'(issue_rd_tag), 64'd10);
    check("wake_rs2", 64'(issue_rs2), 64'hDEAD);
    step();
    check("second_tag", 64'(issue_rd_tag), 64'd11);
    check("second_rs1", 64'(issue_rs1), 64'hB1);
    step();
    check("stall_empty", 64'(empty), 64'd1);

    // 4: dispatch-time CDB bypass
    issue_ready = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'h1234;
    dispatch(6'd12, 1'b0, 6'd5, 32'h0, 1'b1, 6'd0, 32'h55);
    cdb_valid = 1'b0;
    check("byp_valid", 64'(issue_valid), 64'd1);
    check("byp_rs1", 64'(issue_rs1), 64'h1234);
    check("byp_rs2", 64'(issue_rs2), 64'h55);
    issue_ready = 1'b1;
    step();
    check("byp_empty", 64'(empty), 64'd1);

    // 5a: full queue, dispatch + issue same cycle -> dispatch dropped
    issue_ready = 1'b0;
    for (int k = 20; k <= 23; k++)
      dispatch(6'(k), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'(k));
    check("f2_full", 64'(full), 64'd1);
    issue_ready = 1'b1;
    dispatch(6'd24, 1'b1, 6'd0, 32'd24, 1'b1, 6'd0, 32'd24);
    check("f2_not_full", 64'(full), 64'd0);
    check("f2_head", 64'(issue_rd_tag), 64'd21);
    step();
    check("f2_head22", 64'(issue_rd_tag), 64'd22);
    step();
    check("f2_head23", 64'(issue_rd_tag), 64'd23);
    step();
    check("f2_count3_empty", 64'(empty), 64'd1);
    check("f2_no_24", 64'(issue_valid), 64'd0);

    // 5b: flush with two entries plus concurrent dispatch
    issue_ready = 1'b0;
    dispatch(6'd30, 1'b1, 6'd0, 32'h30, 1'b1, 6'd0, 32'h3);
    dispatch(6'd31, 1'b1, 6'd0, 32'h31, 1'b1, 6'd0, 32'h3);
    flush = 1'b1;
    dispatch(6'd32, 1'b1, 6'd0, 32'h32, 1'b1, 6'd0, 32'h3);
    flush = 1'b0;
    check("flush_empty", 64'(empty), 64'd1);
    check("flush_full", 64'(full), 64'd0);
    check("flush_valid", 64'(issue_valid), 64'd0);
    check("flush_hold_tag", 64'(issue_rd_tag), 64'd30);
    issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("post_flush_idle%0d", k), 64'(issue_valid), 64'd0);
    end

    // 6: one CDB tag wakes both operands of two entries; wide tag mismatch ignored
    issue_ready = 1'b0;
    dispatch(6'd40, 1'b0, 6'd7, 32'h0, 1'b0, 6'd7, 32'h0);
    dispatch(6'd41, 1'b0, 6'd7, 32'h0, 1'b0, 6'd7, 32'h0);
    check("w2_pending", 64'(issue_valid), 64'd0);
    cdb(6'd39, 32'hBAD);
    check("w2_tag_msb_mismatch", 64'(issue_valid), 64'd0);
    cdb(6'd7, 32'h77);
    check("w2_valid", 64'(issue_valid), 64'd1);
    check("w2_tag40", 64'(issue_rd_tag), 64'd40);
    check("w2_rs1_40", 64'(issue_rs1), 64'h77);
    check("w2_rs2_40", 64'(issue_rs2), 64'h77);
    issue_ready = 1'b1;
    step();
    check("w2_valid41", 64'(issue_valid), 64'd1);
    check("w2_tag41", 64'(issue_rd_tag), 64'd41);
    check("w2_rs1_41", 64'(issue_rs1), 64'h77);
    check("w2_rs2_41", 64'(issue_rs2), 64'h77);
    step();
    check("w2_empty", 64'(empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
